// File: rtl/bit_register_file.sv
// DEPTH x DATA_WIDTH register bank: one write port with per-word clear, two async read ports.
// Optional REGFILE_BYPASS_EN forwards same-cycle write/clear data to the read ports.
module bit_register_file_word #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic                  clr_i,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] q_o,
    output logic                  written_o,
    output logic                  written_nxt_o
);
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  written_q, written_d;

    // clear beats load when both target this word
    always_comb begin
        word_d    = word_q;
        written_d = written_q;
        if (clr_i) begin
            word_d    = '0;
            written_d = 1'b0;
        end else if (we_i) begin
            word_d    = d_i;
            written_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q    <= '0;
            written_q <= 1'b0;
        end else begin
            word_q    <= word_d;
            written_q <= written_d;
        end
    end

    assign q_o           = word_q;
    assign written_o     = written_q;
    assign written_nxt_o = written_d;
endmodule

module bit_register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [DATA_WIDTH-1:0] out_a,
    output logic [DATA_WIDTH-1:0] out_b,
    output logic [ADDR_WIDTH:0]   wr_count
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] words;
    logic [DEPTH-1:0]                 written;
    logic [DEPTH-1:0]                 written_nxt;
    logic [DEPTH-1:0]                 sel;
    logic [ADDR_WIDTH:0]              wr_count_q, wr_count_d;

    always_comb begin
        sel        = '0;
        sel[waddr] = 1'b1;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        bit_register_file_word #(.DATA_WIDTH(DATA_WIDTH)) u_word (
            .clk          (clk),
            .rst_n        (rst_n),
            .we_i         (load & sel[g]),
            .clr_i        (clr & sel[g]),
            .d_i          (in),
            .q_o          (words[g]),
            .written_o    (written[g]),
            .written_nxt_o(written_nxt[g])
        );
    end

    // count is the popcount of next-state flags so it moves on the same edge
    always_comb begin
        wr_count_d = '0;
        for (int i = 0; i < DEPTH; i++)
            wr_count_d = wr_count_d + {{ADDR_WIDTH{1'b0}}, written_nxt[i]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) wr_count_q <= '0;
        else        wr_count_q <= wr_count_d;
    end

    assign wr_count = wr_count_q;

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        out_a = words[raddr_a];
        out_b = words[raddr_b];
        if (rst_n && raddr_a == waddr) begin
            if (clr)       out_a = '0;
            else if (load) out_a = in;
        end
        if (rst_n && raddr_b == waddr) begin
            if (clr)       out_b = '0;
            else if (load) out_b = in;
        end
    end
`else
    assign out_a = words[raddr_a];
    assign out_b = words[raddr_b];
`endif

    logic unused;
    assign unused = ^written;
endmodule
